// File: rtl/df_pkg.sv
// Return codes and state encodings shared by the dataflow network scheduler.
package df_pkg;
  localparam logic [31:0] RET_IDLE           = 32'd0;
  localparam logic [31:0] RET_WAIT_PREDICATE = 32'd1;
  localparam logic [31:0] RET_WAIT_INPUT     = 32'd2;
  localparam logic [31:0] RET_WAIT_OUTPUT    = 32'd3;
  localparam logic [31:0] RET_WAIT_GUARD     = 32'd4;
  localparam logic [31:0] RET_EXECUTED       = 32'd5;

  typedef logic [2:0] slot_state_t;
  localparam slot_state_t S_OFF     = 3'd0;
  localparam slot_state_t S_LAUNCH  = 3'd1;
  localparam slot_state_t S_BUSY    = 3'd2;
  localparam slot_state_t S_WAIT_IN = 3'd3;
  localparam slot_state_t S_PARK    = 3'd4;

  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_RUN   = 2'd1;
  localparam logic [1:0] T_DRAIN = 2'd2;
  localparam logic [1:0] T_FIN   = 2'd3;

  // network-level commands broadcast to every slot
  typedef struct packed {
    logic launch;
    logic drain;
    logic fin;
  } slot_ctl_t;
endpackage

// File: rtl/df_actor_slot.sv
// One actor slot: launches the actor, decodes its return code, decides relaunch.
module df_actor_slot import df_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  slot_ctl_t   ctl,
  input  logic        actor_done,
  input  logic [31:0] actor_return,
  input  logic        available_data,
  input  logic        others_executing,
  output slot_state_t state,
  output logic        to_launch,
  output logic        exec_hit
);
  slot_state_t nxt;

  always_comb begin
    nxt = state;
    if (ctl.fin) nxt = S_OFF;
    else begin
      case (state)
        S_OFF:     if (ctl.launch) nxt = S_LAUNCH;
        S_LAUNCH:  nxt = ctl.drain ? S_OFF : S_BUSY;
        S_BUSY: begin
          if (actor_done) begin
            if (ctl.drain)                          nxt = S_OFF;
            else if (actor_return == RET_EXECUTED)   nxt = S_LAUNCH;
            else if (actor_return == RET_WAIT_INPUT) nxt = S_WAIT_IN;
            else                                     nxt = S_PARK;
          end
        end
        S_WAIT_IN: if (ctl.drain) nxt = S_OFF; else if (available_data) nxt = S_LAUNCH;
        S_PARK:    if (ctl.drain) nxt = S_OFF; else if (available_data || others_executing) nxt = S_LAUNCH;
        default:   nxt = S_OFF;
      endcase
    end
  end

  assign to_launch = (nxt == S_LAUNCH);
  // an EXECUTED return is counted even while draining
  assign exec_hit  = (state == S_BUSY) && actor_done && (actor_return == RET_EXECUTED);

  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) state <= S_OFF;
    else       state <= nxt;
endmodule

// File: rtl/df_network_scheduler.sv
// Dataflow partition scheduler: network FSM, quiescence detection, fire counter.
module df_network_scheduler import df_pkg::*; #(
  parameter int NUM_ACTORS     = 4,
  parameter int QUIESCE_CYCLES = 8,
  parameter int CNT_W          = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ap_start,
  input  logic                             ap_stop,
  output logic                             ap_done,
  output logic                             ap_idle,
  output logic [NUM_ACTORS-1:0]            actor_start,
  input  logic [NUM_ACTORS-1:0]            actor_done,
  input  logic [NUM_ACTORS-1:0][31:0]      actor_return,
  input  logic [NUM_ACTORS-1:0]            available_data,
  output logic [NUM_ACTORS-1:0]            others_executing,
  output logic [CNT_W-1:0]                 fire_count
);
  localparam int PC_W = $clog2(NUM_ACTORS + 1);

  logic [1:0]                   state, state_nxt;
  slot_state_t [NUM_ACTORS-1:0] slot_st;
  logic [NUM_ACTORS-1:0]        busy, parked, to_launch, exec_hit;
  logic [7:0]                   q_cnt, q_nxt;
  logic [PC_W-1:0]              n_exec;
  logic [CNT_W:0]               fsum;
  logic                         quiet, drain_done;
  slot_ctl_t                    ctl;

  assign ctl.launch = (state == T_IDLE) && ap_start;
  assign ctl.drain  = (state == T_DRAIN);
  assign ctl.fin    = (state == T_FIN);

  for (genvar i = 0; i < NUM_ACTORS; i++) begin : g_slot
    df_actor_slot u_slot (
      .clk              (clk),
      .rst_n            (rst_n),
      .ctl              (ctl),
      .actor_done       (actor_done[i]),
      .actor_return     (actor_return[i]),
      .available_data   (available_data[i]),
      .others_executing (others_executing[i]),
      .state            (slot_st[i]),
      .to_launch        (to_launch[i]),
      .exec_hit         (exec_hit[i])
    );
    assign busy[i]             = (slot_st[i] == S_BUSY);
    assign parked[i]           = (slot_st[i] == S_WAIT_IN) || (slot_st[i] == S_PARK);
    assign others_executing[i] = |(busy & ~(NUM_ACTORS'(1) << i));
    // launches still pending when a stop lands are dropped, not issued
    assign actor_start[i]      = (slot_st[i] == S_LAUNCH) && (state == T_RUN);
  end

  assign quiet      = (&parked) && !(|to_launch);
  assign drain_done = &(~busy | actor_done);
  assign ap_done    = (state == T_FIN);
  assign ap_idle    = (state == T_IDLE);

  always_comb begin
    if (!quiet)                               q_nxt = '0;
    else if (q_cnt == 8'(QUIESCE_CYCLES))     q_nxt = q_cnt;
    else                                      q_nxt = q_cnt + 8'd1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      T_IDLE:  if (ap_start) state_nxt = T_RUN;
      T_RUN:   if (ap_stop) state_nxt = T_DRAIN;
               else if (q_nxt == 8'(QUIESCE_CYCLES)) state_nxt = T_FIN;
      T_DRAIN: if (drain_done) state_nxt = T_FIN;
      default: state_nxt = T_IDLE;
    endcase
  end

  always_comb begin
    n_exec = '0;
    for (int i = 0; i < NUM_ACTORS; i++) n_exec = n_exec + PC_W'(exec_hit[i]);
  end
  assign fsum = {1'b0, fire_count} + (CNT_W+1)'(n_exec);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= T_IDLE;
      q_cnt      <= '0;
      fire_count <= '0;
    end else begin
      state <= state_nxt;
      q_cnt <= (state == T_RUN) ? q_nxt : '0;
      if (ctl.launch)    fire_count <= '0;
      else if (fsum[CNT_W]) fire_count <= '1;
      else               fire_count <= fsum[CNT_W-1:0];
    end
  end
endmodule

// File: doc/df_network_scheduler.md
Name: df_network_scheduler

Overview:
- Sequences NUM_ACTORS HLS actor instances inside one dataflow network partition.
- Launches each actor, collects its return code and relaunches it according to the return-code policy.
- Derives each actor's "others executing" condition from the busy state of its peers.
- Detects network quiescence, then signals network completion to the host-side top level (ap_start/ap_done/ap_idle).

Parameters:
- NUM_ACTORS, 4, number of actor slots (1..32).
- QUIESCE_CYCLES, 8, number of consecutive quiet cycles required to declare the network done (1..255).
- CNT_W, 32, width of the per-network fire counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high (asserted when 1).
- ap_start  in  1  network start request; sampled only in state IDLE.
- ap_stop  in  1  abort request; level-sensitive, honoured in state RUN.
- ap_done  out  1  one-cycle pulse when the network finishes (quiesced or stopped).
- ap_idle  out  1  high while in state IDLE.
- actor_start  out  NUM_ACTORS  per-actor start, one-cycle pulse.
- actor_done  in  NUM_ACTORS  per-actor completion pulse.
- actor_return  in  NUM_ACTORS*32  per-actor return code, valid in the cycle actor_done is high.
- available_data  in  NUM_ACTORS  per-actor "input FIFO non-empty".
- others_executing  out  NUM_ACTORS  bit i = OR of busy[j] for all j != i.
- fire_count  out  CNT_W  number of EXECUTED returns since the last network start; saturates at all-ones.

Behaviour:
- Reset (rst_n=1, asynchronous):
  - top FSM=IDLE; all slots=S_OFF; quiet counter=0; fire_count=0.
  - ap_done=0, ap_idle=1, actor_start=0, others_executing=0.
- Top FSM:
  - IDLE: ap_idle=1. When ap_start=1: clear fire_count and quiet counter, move all slots to S_LAUNCH, go to RUN.
  - RUN:
    - If ap_stop=1, go to DRAIN.
    - Else, if the quiet counter reaches QUIESCE_CYCLES, go to FIN.
  - DRAIN: no new launches. Each slot not in S_BUSY goes to S_OFF. Slots in S_BUSY go to S_OFF on actor_done. When all slots are S_OFF, go to FIN.
  - FIN: ap_done=1 for exactly one cycle; all slots go to S_OFF; next state is IDLE.
- Slot FSM (one per actor):
  - S_OFF: actor_start=0; waits for top-level launch.
  - S_LAUNCH: actor_start[i]=1 for one cycle, then S_BUSY.
  - S_BUSY: busy[i]=1. On actor_done[i], decode actor_return[i]:
    - EXECUTED(5): go to S_LAUNCH; fire_count += 1 (saturating).
    - WAIT_INPUT(2): go to S_WAIT_IN.
    - any other code (0,1,3,4,>5): go to S_PARK.
  - S_WAIT_IN: go to S_LAUNCH when available_data[i]=1.
  - S_PARK: go to S_LAUNCH when available_data[i]=1 or others_executing[i]=1.
- Handshake edge cases:
  - A done pulse in the same cycle as launch cannot occur; actor_done in S_LAUNCH is ignored.
  - actor_done outside S_BUSY is ignored.
- Quiet condition:
  - A cycle is quiet when every slot is in S_WAIT_IN or S_PARK, no bit of busy is set, and no slot transitions to S_LAUNCH that cycle.
  - The quiet counter increments on quiet cycles (saturating at QUIESCE_CYCLES) and clears on any non-quiet cycle.
- Simultaneous events:
  - Multiple actor_done in one cycle each raise fire_count by the count of EXECUTED returns; the adder sums popcount.
  - ap_stop together with quiescence: stop wins (DRAIN).
  - ap_start during RUN, DRAIN or FIN is ignored.
- others_executing is combinational from registered busy bits; no latency.
- Reset mid-operation forces all outputs to their reset values immediately; in-flight actor results are dropped.

Decomposition:
- Shared package df_pkg:
  - return-code constants RET_IDLE=0, RET_WAIT_PREDICATE=1, RET_WAIT_INPUT=2, RET_WAIT_OUTPUT=3, RET_WAIT_GUARD=4, RET_EXECUTED=5.
  - slot state encoding and top state encoding.
- Sub-module df_actor_slot: the slot FSM, instantiated NUM_ACTORS times via generate.
- The top level holds the network FSM, quiet counter, fire counter and the others_executing reduction.

Test Plan:
1. Reset: hold rst_n=1 for 3 cycles, then release -> ap_idle=1, ap_done=0, actor_start=0, fire_count=0.
2. NUM_ACTORS=2. Pulse ap_start. Actor0 returns 5 three times then 2; actor1 returns 4 once; no available_data -> actor_start[0] pulses 4 times; actor1 relaunches while actor0 is busy; fire_count=3; ap_done pulses QUIESCE_CYCLES=8 cycles after the last busy cycle.
3. WAIT_INPUT: actor0 returns 2; after 5 cycles raise available_data[0] -> actor_start[0] pulses exactly 1 cycle after the rise; the quiet counter clears.
4. Stop: ap_stop=1 while actor1 is busy -> no further actor_start; ap_done pulses 1 cycle after actor_done[1].
5. Simultaneous: both actors return 5 in the same cycle -> fire_count increments by 2; both actor_start bits pulse the next cycle.
6. Async reset: assert rst_n mid-RUN between clock edges -> actor_start=0 and ap_idle=1 before the next edge; fire_count=0.
